elevator_ctrl: RTL and testbench

Four-floor single-car elevator controller. It latches hall calls (up at floors 1-3, down at floors 2-4) and car calls (floors 1-4) into request lamps. It runs a collective (SCAN) dispatch and sequences car motion and door opening on fixed cycle timers. It sits between the button/lamp panel and the motor/door drive, and reports car floor, direction and door state.

---
 rtl/elevator_ctrl_if.sv | 17 +
 rtl/elevator_ctrl.sv | 122 ++++++++++++
 tb/tb_elevator_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: button/lamp panel and car status bundle between panel (master) and controller (slave)
interface elevator_ctrl_if;
  logic U1, U2, U3, D2, D3, D4, F1, F2, F3, F4;
  logic U1_led, U2_led, U3_led, D2_led, D3_led, D4_led, F1_led, F2_led, F3_led, F4_led;
  logic Opened;
  logic [1:0] Direction, Floor;
  modport master (
    output U1, U2, U3, D2, D3, D4, F1, F2, F3, F4,
    input  U1_led, U2_led, U3_led, D2_led, D3_led, D4_led, F1_led, F2_led, F3_led, F4_led,
    input  Opened, Direction, Floor
  );
  modport slave (
    input  U1, U2, U3, D2, D3, D4, F1, F2, F3, F4,
    output U1_led, U2_led, U3_led, D2_led, D3_led, D4_led, F1_led, F2_led, F3_led, F4_led,
    output Opened, Direction, Floor
  );
endinterface

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: four-floor single-car SCAN controller with latched calls and fixed move/door timers
module elevator_ctrl #(
  parameter int T_MOVE = 4,
  parameter int T_DOOR = 4
) (
  input logic clk,
  input logic rst,
  elevator_ctrl_if.slave io
);
  localparam int TW = $clog2((T_MOVE > T_DOOR ? T_MOVE : T_DOOR) + 1);
  localparam logic [1:0] D_IDLE = 2'b00, D_UP = 2'b01, D_DN = 2'b10;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t state, state_n;
  logic [1:0] floor, floor_n, dir, dir_n, nf, fs;
  logic [TW-1:0] tmr, tmr_n;
  logic opened, opened_n;
  logic [3:0] up, dn, car, up_n, dn_n, car_n;
  logic [3:0] up_b, dn_b, car_b, up_e, dn_e, car_e, req, oh, cu, cd, cc;
  logic kd_up, ah, ah_o, stop, hit;
  function automatic logic ahead(input logic [1:0] f, input logic go_up, input logic [3:0] r);
    logic [3:0] m;
    m = go_up ? 4'b1110 << f : ~(4'b1111 << f);
    return |(r & m);
  endfunction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      floor <= 2'd0;
      dir <= D_IDLE;
      tmr <= '0;
      opened <= 1'b0;
      up <= 4'b0;
      dn <= 4'b0;
      car <= 4'b0;
    end else begin
      state <= state_n;
      floor <= floor_n;
      dir <= dir_n;
      tmr <= tmr_n;
      opened <= opened_n;
      up <= up_n;
      dn <= dn_n;
      car <= car_n;
    end
  // Decisions see pending lamps plus this edge's presses, so a call at the idle floor opens without ever lighting.
  always_comb begin
    up_b = {1'b0, io.U3, io.U2, io.U1};
    dn_b = {io.D4, io.D3, io.D2, 1'b0};
    car_b = {io.F4, io.F3, io.F2, io.F1};
    up_e = up | up_b;
    dn_e = dn | dn_b;
    car_e = car | car_b;
    req = up_e | dn_e | car_e;
    kd_up = dir != D_DN;
    nf = kd_up ? floor + 2'd1 : floor - 2'd1;
    fs = state == MOVE ? nf : floor;
    oh = 4'b0001 << fs;
    ah = ahead(fs, kd_up, req);
    ah_o = ahead(floor, !kd_up, req);
    cc = oh;
    cu = (dir != D_DN || !ah) ? oh : 4'b0;
    cd = (dir != D_UP || !ah) ? oh : 4'b0;
    stop = car_e[nf] || (kd_up ? up_e[nf] : dn_e[nf]) || (!ah && (kd_up ? dn_e[nf] : up_e[nf])) || nf == 2'd0 || nf == 2'd3;
    hit = |((up_b & cu) | (dn_b & cd) | (car_b & cc));
    state_n = state;
    floor_n = floor;
    dir_n = dir;
    tmr_n = tmr;
    opened_n = opened;
    up_n = up_e;
    dn_n = dn_e;
    car_n = car_e;
    case (state)
      IDLE: begin
        opened_n = 1'b0;
        if (ah || ah_o) begin
          state_n = MOVE;
          dir_n = (kd_up == ah) ? D_UP : D_DN;
          tmr_n = TW'(T_MOVE - 1);
        end else if (req[floor]) begin
          state_n = DOOR;
          opened_n = 1'b1;
          tmr_n = TW'(T_DOOR - 1);
          up_n = up_e & ~cu;
          dn_n = dn_e & ~cd;
          car_n = car_e & ~cc;
        end else dir_n = D_IDLE;
      end
      MOVE: begin
        tmr_n = tmr == '0 ? TW'(T_MOVE - 1) : tmr - 1'b1;
        if (tmr == '0) begin
          floor_n = nf;
          if (stop) begin
            state_n = DOOR;
            opened_n = 1'b1;
            tmr_n = TW'(T_DOOR - 1);
            up_n = up_e & ~cu;
            dn_n = dn_e & ~cd;
            car_n = car_e & ~cc;
          end
        end
      end
      DOOR: begin
        up_n = up_e & ~cu;
        dn_n = dn_e & ~cd;
        car_n = car_e & ~cc;
        tmr_n = hit ? TW'(T_DOOR - 1) : (tmr == '0 ? tmr : tmr - 1'b1);
        if (!hit && tmr == '0) begin
          state_n = IDLE;
          opened_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign {io.U1_led, io.U2_led, io.U3_led} = {up[0], up[1], up[2]};
  assign {io.D2_led, io.D3_led, io.D4_led} = {dn[1], dn[2], dn[3]};
  assign {io.F1_led, io.F2_led, io.F3_led, io.F4_led} = {car[0], car[1], car[2], car[3]};
  assign io.Opened = opened;
  assign io.Direction = dir;
  assign io.Floor = floor;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed scenarios with hand-computed lamp/door/floor expectations
module tb_elevator_ctrl;
  localparam logic [9:0] B_U3 = 10'h080, B_D2 = 10'h040, B_D4 = 10'h010;
  localparam logic [9:0] B_F1 = 10'h008, B_F2 = 10'h004, B_F4 = 10'h001;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  elevator_ctrl_if io();
  elevator_ctrl #(.T_MOVE(4), .T_DOOR(4)) dut (.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] leds();
    return {io.U1_led, io.U2_led, io.U3_led, io.D2_led, io.D3_led, io.D4_led,
            io.F1_led, io.F2_led, io.F3_led, io.F4_led};
  endfunction
  task automatic press(input logic [9:0] b);
    {io.U1, io.U2, io.U3, io.D2, io.D3, io.D4, io.F1, io.F2, io.F3, io.F4} = b;
    @(negedge clk);
    {io.U1, io.U2, io.U3, io.D2, io.D3, io.D4, io.F1, io.F2, io.F3, io.F4} = 10'h000;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic status(input string tag, input int op, input int dr, input int fl);
    check({tag, ".opened"}, int'(io.Opened), op);
    check({tag, ".dir"}, int'(io.Direction), dr);
    check({tag, ".floor"}, int'(io.Floor), fl);
  endtask
  initial begin
    {io.U1, io.U2, io.U3, io.D2, io.D3, io.D4, io.F1, io.F2, io.F3, io.F4} = 10'h000;
    tick(4);
    check("rst.leds", int'(leds()), 0);
    status("rst", 0, 0, 0);
    rst = 1'b1;
    tick(2);
    check("idle.leds", int'(leds()), 0);
    status("idle", 0, 0, 0);
    // sweep: D2, D4, F4 from floor 1
    press(B_D2 | B_D4 | B_F4);
    check("sweep.latch", int'(leds()), 'h051);
    status("sweep.start", 0, 1, 0);
    tick(3);
    check("sweep.f1hold", int'(io.Floor), 0);
    tick(1);
    status("sweep.f2", 0, 1, 1);
    tick(4);
    status("sweep.f3", 0, 1, 2);
    tick(4);
    status("sweep.f4", 1, 1, 3);
    check("sweep.f4clr", int'(leds()), 'h040);
    tick(1);
    press(B_D4);
    check("ext.leds", int'(leds()), 'h040);
    check("ext.open", int'(io.Opened), 1);
    tick(3);
    check("ext.still", int'(io.Opened), 1);
    tick(1);
    check("ext.close", int'(io.Opened), 0);
    tick(1);
    status("sweep.down", 0, 2, 3);
    tick(8);
    status("sweep.f2stop", 1, 2, 1);
    check("sweep.d2clr", int'(leds()), 0);
    tick(3);
    check("sweep.door4", int'(io.Opened), 1);
    tick(1);
    check("sweep.close", int'(io.Opened), 0);
    tick(1);
    status("sweep.idle", 0, 0, 1);
    // call at current floor
    press(B_F2);
    check("here.leds", int'(leds()), 0);
    status("here.open", 1, 0, 1);
    tick(3);
    check("here.door4", int'(io.Opened), 1);
    tick(1);
    status("here.close", 0, 0, 1);
    // return to floor 1
    press(B_F1);
    check("home.dir", int'(io.Direction), 2);
    tick(4);
    status("home.arrive", 1, 2, 0);
    check("home.leds", int'(leds()), 0);
    tick(5);
    status("home.idle", 0, 0, 0);
    // direction priority: U3 then D2 mid-travel
    press(B_U3);
    check("prio.u3", int'(leds()), 'h080);
    check("prio.dir", int'(io.Direction), 1);
    tick(1);
    press(B_D2);
    check("prio.d2", int'(leds()), 'h0C0);
    tick(2);
    status("prio.pass2", 0, 1, 1);
    tick(4);
    status("prio.stop3", 1, 1, 2);
    check("prio.u3clr", int'(leds()), 'h040);
    tick(5);
    status("prio.rev", 0, 2, 2);
    tick(4);
    status("prio.stop2", 1, 2, 1);
    check("prio.d2clr", int'(leds()), 0);
    tick(4);
    check("prio.close", int'(io.Opened), 0);
    // async reset while moving up between floors
    press(B_F4);
    tick(2);
    check("ar.led", int'(leds()), 'h001);
    status("ar.moving", 0, 1, 1);
    #2 rst = 1'b0;
    #1;
    check("ar.leds", int'(leds()), 0);
    status("ar", 0, 0, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    status("ar.after", 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
